// File: rtl/player_blitter.sv
// Purpose : scans every screen pixel, queries the player block, and copies
//           non-transparent sprite texels into the frame buffer.
// Latency : a pixel issued in SCAN reaches fb_we two cycles later; done pulses
//           once the pipeline has emptied after the last pixel.
// Backpressure: fb_we && !fb_ready freezes the scan counters and both stages.
//
// Ports:
//   Clk, Reset      system clock, synchronous active-high reset
//   frame_clk       frame tick; its rising edge starts a blit when idle
//   PixelX/PixelY   query coordinates to the player block
//   is_player       hit flag for PixelX/PixelY (combinational, from player block)
//   player_address  sprite ROM address paired with is_player
//   rom_address     registered ROM read address; rom_data is valid a cycle later
//   rom_data        sprite colour index
//   fb_we/fb_addr/fb_data/fb_ready  frame-buffer write handshake
//   busy            high while a blit is in progress
//   done            one-cycle pulse when a blit completes
module player_blitter #(
    parameter int       SCREEN_W    = 320,
    parameter int       SCREEN_H    = 240,
    parameter logic [3:0] TRANSPARENT = 4'd0
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        frame_clk,
    output logic [8:0]  PixelX,
    output logic [8:0]  PixelY,
    input  logic        is_player,
    input  logic [11:0] player_address,
    output logic [11:0] rom_address,
    input  logic [3:0]  rom_data,
    output logic        fb_we,
    output logic [16:0] fb_addr,
    output logic [3:0]  fb_data,
    input  logic        fb_ready,
    output logic        busy,
    output logic        done
);

    localparam logic [8:0] X_LAST = 9'(SCREEN_W - 1);
    localparam logic [8:0] Y_LAST = 9'(SCREEN_H - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t      state;
    logic        frame_q;      // delayed copy of frame_clk
    logic        frame_edge;   // registered rising-edge flag
    logic [16:0] lin_addr;     // Y*SCREEN_W+X, kept by incrementing alongside X/Y
    logic        v1;           // stage 1: hit pending ROM read
    logic [16:0] a1;           // stage 1: frame-buffer address of that hit
    logic        v2;           // stage 2: write pending
    logic        stall;

    assign fb_we = v2;
    assign stall = v2 && !fb_ready;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state       <= IDLE;
            // Track the live level so a frame_clk already high across Reset
            // is not mistaken for a fresh edge once Reset drops.
            frame_q     <= frame_clk;
            frame_edge  <= 1'b0;
            PixelX      <= 9'd0;
            PixelY      <= 9'd0;
            lin_addr    <= 17'd0;
            rom_address <= 12'd0;
            v1          <= 1'b0;
            a1          <= 17'd0;
            v2          <= 1'b0;
            fb_addr     <= 17'd0;
            fb_data     <= 4'd0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            frame_q    <= frame_clk;
            frame_edge <= frame_clk && !frame_q;
            done       <= 1'b0;

            // Stage 2 consumes stage 1 whenever the output is not blocked;
            // stage 1 defaults to empty and is refilled below only in SCAN.
            if (!stall) begin
                v2      <= v1 && (rom_data != TRANSPARENT);
                fb_data <= rom_data;
                fb_addr <= a1;
                v1      <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (frame_edge) begin
                        state    <= SCAN;
                        busy     <= 1'b1;
                        PixelX   <= 9'd0;
                        PixelY   <= 9'd0;
                        lin_addr <= 17'd0;
                    end
                end
                SCAN: begin
                    if (!stall) begin
                        rom_address <= player_address;
                        v1          <= is_player;
                        a1          <= lin_addr;
                        if (PixelX == X_LAST && PixelY == Y_LAST) begin
                            state <= DRAIN;
                        end else begin
                            lin_addr <= lin_addr + 17'd1;
                            if (PixelX == X_LAST) begin
                                PixelX <= 9'd0;
                                PixelY <= PixelY + 9'd1;
                            end else begin
                                PixelX <= PixelX + 9'd1;
                            end
                        end
                    end
                end
                DRAIN: begin
                    // Finished once stage 1 is empty and stage 2 is empty or
                    // its write is being accepted on this edge.
                    if (!v1 && (!v2 || fb_ready)) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_player_blitter.sv
// Purpose : randomized self-checking bench for player_blitter on a reduced screen.
// Latency : n/a (bench).
// Backpressure: fb_ready is driven always-high, random, or held low on the first write.
module tb_player_blitter;

    localparam int W  = 64;
    localparam int H  = 48;
    localparam int PW = 16;
    localparam int PH = 12;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        frame_clk = 1'b0;
    logic [8:0]  PixelX;
    logic [8:0]  PixelY;
    logic        is_player;
    logic [11:0] player_address;
    logic [11:0] rom_address;
    logic [3:0]  rom_data;
    logic        fb_we;
    logic [16:0] fb_addr;
    logic [3:0]  fb_data;
    logic        fb_ready = 1'b1;
    logic        busy;
    logic        done;

    int checks = 0;
    int failures = 0;

    // Player placement and sprite contents (written by the main process only).
    int         px = 0;
    int         py = 0;
    logic [3:0] rom_mem [4096];
    int         exp_addr[$];
    int         exp_dat[$];

    // Write log and event counters (written by the monitor only).
    int log_addr[$];
    int log_dat[$];
    int wr_count = 0;
    int done_cyc = 0;
    int busy_rises = 0;
    int stall_cyc = 0;
    int stall_bad = 0;

    // fb_ready control.
    int rdy_mode = 0;
    int hold_req = 0;
    int hold_used = 0;

    always #10 Clk = ~Clk;

    player_blitter #(
        .SCREEN_W   (W),
        .SCREEN_H   (H),
        .TRANSPARENT(4'd0)
    ) dut (
        .Clk           (Clk),
        .Reset         (Reset),
        .frame_clk     (frame_clk),
        .PixelX        (PixelX),
        .PixelY        (PixelY),
        .is_player     (is_player),
        .player_address(player_address),
        .rom_address   (rom_address),
        .rom_data      (rom_data),
        .fb_we         (fb_we),
        .fb_addr       (fb_addr),
        .fb_data       (fb_data),
        .fb_ready      (fb_ready),
        .busy          (busy),
        .done          (done)
    );

    // Player block: a PW x PH rectangle at (px,py), row-major sprite address.
    always_comb begin
        is_player = (int'(PixelX) >= px) && (int'(PixelX) < px + PW) &&
                    (int'(PixelY) >= py) && (int'(PixelY) < py + PH);
        player_address = 12'd0;
        if (is_player)
            player_address = 12'((int'(PixelY) - py) * PW + (int'(PixelX) - px));
    end

    // Sprite ROM: data follows the registered address within the cycle.
    assign rom_data = rom_mem[rom_address];

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Monitor: logs accepted writes and watches hold behaviour during stalls.
    bit         prev_stall = 1'b0;
    bit         prev_busy = 1'b0;
    logic [16:0] prev_addr;
    logic [3:0]  prev_dat;
    logic [8:0]  prev_x;
    logic [8:0]  prev_y;
    always @(negedge Clk) begin
        if (!Reset) begin
            if (prev_stall) begin
                if (!fb_we || fb_addr != prev_addr || fb_data != prev_dat ||
                    PixelX != prev_x || PixelY != prev_y)
                    stall_bad++;
            end
            if (fb_we && fb_ready) begin
                log_addr.push_back(int'(fb_addr));
                log_dat.push_back(int'(fb_data));
                wr_count++;
            end
            if (fb_we && !fb_ready) stall_cyc++;
            if (done) done_cyc++;
            if (busy && !prev_busy) busy_rises++;
        end
        prev_stall = !Reset && fb_we && !fb_ready;
        prev_addr  = fb_addr;
        prev_dat   = fb_data;
        prev_x     = PixelX;
        prev_y     = PixelY;
        prev_busy  = busy;
    end

    // fb_ready driver.
    initial begin
        forever begin
            @(posedge Clk);
            #1;
            if (rdy_mode == 0) begin
                fb_ready = 1'b1;
            end else if (rdy_mode == 1) begin
                fb_ready = ($urandom_range(0, 3) != 0);
            end else begin
                fb_ready = 1'b1;
                if (fb_we && hold_used != hold_req) begin
                    fb_ready = 1'b0;
                    repeat (5) @(posedge Clk);
                    #1;
                    fb_ready = 1'b1;
                    hold_used = hold_req;
                end
            end
        end
    end

    // rom_kind: 0 all 5, 1 even addresses transparent, 2 random
    task automatic fill_rom(input int rom_kind);
        for (int a = 0; a < 4096; a++) begin
            if (rom_kind == 0)
                rom_mem[a] = 4'd5;
            else if (rom_kind == 1)
                rom_mem[a] = (a % 2 == 0) ? 4'd0 : 4'($urandom_range(1, 15));
            else
                rom_mem[a] = 4'($urandom_range(0, 15));
        end
    endtask

    // Reference: every screen pixel in raster order, write iff hit and opaque.
    task automatic build_expected();
        int sa;
        exp_addr.delete();
        exp_dat.delete();
        for (int y = 0; y < H; y++) begin
            for (int x = 0; x < W; x++) begin
                if (x >= px && x < px + PW && y >= py && y < py + PH) begin
                    sa = (y - py) * PW + (x - px);
                    if (rom_mem[sa] != 4'd0) begin
                        exp_addr.push_back(y * W + x);
                        exp_dat.push_back(int'(rom_mem[sa]));
                    end
                end
            end
        end
    endtask

    task automatic pulse_frame();
        @(negedge Clk);
        frame_clk = 1'b1;
        repeat (3) @(negedge Clk);
        frame_clk = 1'b0;
    endtask

    int w0;
    int s0;

    task automatic run_blit(input string tag, input int npx, input int npy,
                            input int rom_kind, input int rdy, input bit mid_edge);
        int d0, b0, sb0, cyc, n, idx;
        px = npx;
        py = npy;
        fill_rom(rom_kind);
        if (rom_kind == 2) rom_mem[PW * PH - 1] = 4'd9;
        build_expected();
        rdy_mode = rdy;
        if (rdy == 2) hold_req++;
        w0  = wr_count;
        s0  = stall_cyc;
        d0  = done_cyc;
        b0  = busy_rises;
        sb0 = stall_bad;
        pulse_frame();
        if (mid_edge) begin
            repeat (400) @(negedge Clk);
            check({tag, "_busy_mid"}, int'(busy), 1);
            pulse_frame();
        end
        cyc = 0;
        while (done_cyc == d0 && cyc < 8000) begin
            @(negedge Clk);
            cyc++;
        end
        check({tag, "_done_seen"}, int'(cyc < 8000), 1);
        repeat (20) @(negedge Clk);
        n = wr_count - w0;
        check({tag, "_writes"}, n, exp_addr.size());
        for (int i = 0; i < n && i < exp_addr.size(); i++) begin
            idx = w0 + i;
            check({tag, "_wr_addr"}, log_addr[idx], exp_addr[i]);
            check({tag, "_wr_dat"}, log_dat[idx], exp_dat[i]);
        end
        check({tag, "_done_cycles"}, done_cyc - d0, 1);
        check({tag, "_busy_rises"}, busy_rises - b0, 1);
        check({tag, "_busy_after"}, int'(busy), 0);
        check({tag, "_stall_hold"}, stall_bad - sb0, 0);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_pixel_x"}, int'(PixelX), 0);
        check({tag, "_pixel_y"}, int'(PixelY), 0);
        check({tag, "_rom_address"}, int'(rom_address), 0);
        check({tag, "_fb_we"}, int'(fb_we), 0);
        check({tag, "_fb_addr"}, int'(fb_addr), 0);
        check({tag, "_fb_data"}, int'(fb_data), 0);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_done"}, int'(done), 0);
    endtask

    initial begin
        int w1, d1, b1, cyc;
        repeat (3) @(posedge Clk);
        #1;
        check_reset_values("reset");
        @(negedge Clk);
        Reset = 1'b0;
        repeat (5) @(negedge Clk);

        // Player at origin, solid sprite, no backpressure.
        run_blit("origin", 0, 0, 0, 0, 1'b0);
        check("origin_count", wr_count - w0, PW * PH);
        check("origin_first", log_addr[w0], 0);
        check("origin_last", log_addr[wr_count - 1], (PH - 1) * W + PW - 1);

        // Even sprite addresses transparent.
        run_blit("even_transp", 20, 10, 1, 0, 1'b0);
        check("even_transp_count", wr_count - w0, PW * PH / 2);

        // First write held off for five cycles.
        run_blit("hold5", 30, 20, 0, 2, 1'b0);
        check("hold5_stall_cycles", stall_cyc - s0, 5);
        check("hold5_first", log_addr[w0], 20 * W + 30);

        // Random placement, random sprite, random backpressure.
        for (int k = 0; k < 2; k++)
            run_blit("random", $urandom_range(0, W - PW), $urandom_range(0, H - PH), 2, 1, 1'b0);

        // Extra frame edge while busy must be ignored.
        run_blit("mid_edge", 5, 7, 2, 1, 1'b0 | 1'b1);

        // Sprite in the bottom-right corner: last screen pixel is a hit.
        run_blit("corner", W - PW, H - PH, 2, 1, 1'b0);
        check("corner_last", log_addr[wr_count - 1], W * H - 1);

        // Reset in the middle of a blit.
        px = 0;
        py = 0;
        fill_rom(0);
        rdy_mode = 0;
        w0 = wr_count;
        pulse_frame();
        cyc = 0;
        while (wr_count - w0 < 100 && cyc < 5000) begin
            @(negedge Clk);
            cyc++;
        end
        check("abort_reached_100", int'(cyc < 5000), 1);
        @(posedge Clk);
        #2;
        Reset = 1'b1;
        frame_clk = 1'b1;
        @(posedge Clk);
        #1;
        check_reset_values("abort");
        repeat (3) @(negedge Clk);
        Reset = 1'b0;
        w1 = wr_count;
        d1 = done_cyc;
        b1 = busy_rises;
        repeat (60) @(negedge Clk);
        check("abort_busy", int'(busy), 0);
        check("abort_no_writes", wr_count - w1, 0);
        check("abort_no_done", done_cyc - d1, 0);
        check("abort_no_restart", busy_rises - b1, 0);
        frame_clk = 1'b0;
        repeat (5) @(negedge Clk);

        // New edge after abort starts a fresh, complete blit.
        run_blit("recover", $urandom_range(0, W - PW), $urandom_range(0, H - PH), 2, 1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
